demux_1to8_deser: RTL and testbench
===================================

# demux_1to8_deser

Serial-to-parallel receiver: the demultiplexing counterpart of the 8-to-1 select path. It steers a one-bit stream into eight word slots using an internal 3-bit select counter, then presents each completed byte on a valid/ready output holding register. It sits at the receive end of a serialized link whose transmitter walks select 0→7, so slot k receives data bit k.

## Interface
- `LSB_FIRST`, default 1
  - 1: the k-th accepted bit of a word lands in `dout[k]`.
  - 0: the k-th accepted bit of a word lands in `dout[7-k]`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sync_clr`  in  1  synchronous abort of the partial word; also clears `overflow`.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is accepted on this edge.
- `dout`  out  8  completed word.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` on this edge when `dout_valid`=1.
- `sel`  out  3  slot index the next accepted data bit is written to.
- `overflow`  out  1  sticky; a completed word was dropped.
- `parity_err`  out  1  parity result for the word in `dout`; see Configuration.

## Operation
- **Collector:** 3-bit counter `sel` plus 8-bit accumulator `acc`.
  - On an edge with `din_valid`=1 and `sync_clr`=0: write `din` into `acc[LSB_FIRST ? sel : 7-sel]`, then `sel` ← `sel`+1 mod 8.
  - `din_valid`=0: `sel` and `acc` hold. Gaps of any length are legal.
- **Word completion:** acceptance of a bit while `sel`=7 completes the word. The completed word is `acc` with that bit merged, and `sel` wraps to 0.
- **Output buffer FSM**, two states:
  - EMPTY (`dout_valid`=0) → FULL on word completion; `dout` is loaded with the completed word.
  - FULL → EMPTY on `dout_ready`=1 with no completion on the same edge.
  - FULL, `dout_ready`=1 and completion on the same edge: stays FULL, `dout` reloads with the new word (back-to-back, no bubble).
  - FULL, `dout_ready`=0 and completion: the new word is discarded, `dout` is unchanged and `overflow` ← 1.
- `dout` is stable whenever `dout_valid`=1 and no handoff occurs.
- **`sync_clr`=1:** `sel` ← 0, `acc` ← 0, `overflow` ← 0.
  - A `din` offered on the same edge is discarded.
  - A pending `dout`/`dout_valid` is not affected, and `dout_ready` handoff still occurs.
- **`overflow`** clears only on `sync_clr` or reset.

## Timing
- Reset values (asynchronous on `rst_n` low): `dout`=8'h00, `dout_valid`=0, `sel`=3'b000, `overflow`=0, `parity_err`=0; `acc`=8'h00.
- Reset mid-word discards the partial word and any pending `dout`.
- Latency: `dout_valid` rises immediately after the edge that accepts the word's final bit. Minimum is 8 cycles from the first bit with continuous `din_valid`.
- Sustained throughput: one word per 8 `din_valid` cycles, with zero loss when `dout_ready` is held at 1.
- `sel` is registered and updates on the accepting edge, so it always names the next slot.
- No combinational path from `din`/`din_valid` to any output; `dout_ready` affects outputs only through registers.

## Configuration
- Macro: `DEMUX_PARITY_EN`.
- **Defined:**
  - Each frame is 8 data bits followed by one even-parity bit.
  - After the data bit in slot 7 is accepted, `sel` holds 0 and an internal parity-phase flag is set. The next accepted bit is the parity bit and completes the word.
  - `parity_err` is registered with `dout`: 1 iff the XOR of the 8 data bits and the parity bit is 1.
  - Overflow, `sync_clr` and reset rules apply to the full 9-bit frame. `sync_clr` also clears the parity-phase flag.
- **Undefined:** frames are 8 bits, and `parity_err` is tied to 0.

## Test plan
- **LSB_FIRST=1, byte 0xAA:** bits 0,1,0,1,0,1,0,1 with continuous `din_valid` and `dout_ready`=1 → `dout`=8'hAA, `dout_valid` high for 1 cycle after the 8th edge, `sel` back to 0.
- **LSB_FIRST=0, byte 0xCC:** same serial sequence as 0xCC LSB-first with `din_valid` toggling every other cycle → `dout`=8'h33. Gaps must not shift slots.
- **Backpressure:** `dout_ready`=0; send 8'h0F then 8'hF0 → `dout` stays 8'h0F, `overflow`=1. Assert `sync_clr` → `overflow`=0, `dout` still 8'h0F.
- **Simultaneous events:** `dout_ready`=1 on the edge completing a second word → `dout_valid` never drops, and `dout` goes from the first word to the second in one edge.
- **Abort and reset:**
  - `sync_clr` after 3 bits, then 8 bits of 8'h5A → `dout`=8'h5A.
  - Separately, `rst_n` low after 5 bits → all outputs at reset values asynchronously, and the next full word decodes correctly.
- **With `DEMUX_PARITY_EN`:**
  - 8'hAA with parity bit 0 → `parity_err`=0.
  - 8'hAB with parity bit 0 → `parity_err`=1.

Source files
------------

// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel receiver: steers a 1-bit stream into 8 slots and hands each byte out via valid/ready.
// Optional feature macro: DEMUX_PARITY_EN (9-bit frames with a trailing even-parity bit).
module demux_1to8_deser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_clr,
    input  logic       din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [2:0] sel,
    output logic       overflow,
    output logic       parity_err,
    output logic       state_dbg
);

    // Output handshake: a word transfers on any edge where dout_valid=1 and dout_ready=1;
    // dout holds steady while dout_valid=1 and no transfer occurs.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t state_q, state_d;

    logic [2:0] sel_q;
    logic [7:0] acc_q;
    logic [7:0] acc_merged;
    logic [2:0] slot;
    logic       accept;
    logic       complete;
    logic [7:0] word;
    logic       perr_new;
    logic       load;
    logic       ovf_set;
    logic [7:0] dout_q;
    logic       perr_q;
    logic       ovf_q;

    assign accept = din_valid & ~sync_clr;
    assign slot   = LSB_FIRST ? sel_q : (3'd7 - sel_q);

    always_comb begin
        acc_merged       = acc_q;
        acc_merged[slot] = din;
    end

`ifdef DEMUX_PARITY_EN
    logic phase_q;

    // The parity bit completes the frame; the data byte is already fully in acc.
    assign complete = accept & phase_q;
    assign word     = acc_q;
    assign perr_new = ^{acc_q, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 3'd0;
            acc_q   <= 8'h00;
            phase_q <= 1'b0;
        end else if (sync_clr) begin
            sel_q   <= 3'd0;
            acc_q   <= 8'h00;
            phase_q <= 1'b0;
        end else if (din_valid) begin
            if (phase_q) begin
                phase_q <= 1'b0;
            end else begin
                acc_q <= acc_merged;
                sel_q <= sel_q + 3'd1;
                if (sel_q == 3'd7) begin
                    phase_q <= 1'b1;
                end
            end
        end
    end
`else
    assign complete = accept & (sel_q == 3'd7);
    assign word     = acc_merged;
    assign perr_new = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 3'd0;
            acc_q <= 8'h00;
        end else if (sync_clr) begin
            sel_q <= 3'd0;
            acc_q <= 8'h00;
        end else if (din_valid) begin
            acc_q <= acc_merged;
            sel_q <= sel_q + 3'd1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                // A completion while the consumer stalls is dropped, not queued.
                if (complete) begin
                    if (dout_ready) begin
                        load = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (dout_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            dout_q  <= 8'h00;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                dout_q <= word;
                perr_q <= perr_new;
            end
            if (sync_clr) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == FULL);
    assign sel        = sel_q;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Bench for demux_1to8_deser: an LSB-first and an MSB-first instance share one stimulus stream
// and are checked every cycle against a bit-queue reference model plus fixed vectors.
module tb_demux_1to8_deser;

`ifdef DEMUX_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_clr, din, din_valid, dout_ready;
    logic [7:0] dout_l, dout_m;
    logic       valid_l, valid_m, ovf_l, ovf_m, perr_l, perr_m, st_l, st_m;
    logic [2:0] sel_l, sel_m;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic       bits_q[$];
    logic       m_valid;
    logic [7:0] m_word;
    logic       m_perr;
    logic       m_ovf;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] byte_in;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;
    vec_t vecs[6];

    demux_1to8_deser #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .din(din), .din_valid(din_valid),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready), .sel(sel_l),
        .overflow(ovf_l), .parity_err(perr_l), .state_dbg(st_l)
    );

    demux_1to8_deser #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .din(din), .din_valid(din_valid),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready), .sel(sel_m),
        .overflow(ovf_m), .parity_err(perr_m), .state_dbg(st_m)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        m_valid = 1'b0;
        m_word  = 8'h00;
        m_perr  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One rising edge of the reference: collect bits, form a frame, then apply buffer rules.
    task automatic model_edge(input logic d, input logic dv, input logic rdy, input logic clr);
        logic       done;
        logic [7:0] w;
        logic       p;
        done = 1'b0;
        w    = 8'h00;
        p    = 1'b0;
        if (clr) begin
            bits_q.delete();
            m_ovf = 1'b0;
        end else if (dv) begin
            bits_q.push_back(d);
            if (bits_q.size() == FRAME) begin
                done = 1'b1;
                for (int k = 0; k < 8; k++) w[k] = bits_q[k];
`ifdef DEMUX_PARITY_EN
                p = ^w ^ bits_q[8];
`endif
                bits_q.delete();
            end
        end
        if (m_valid) begin
            if (done && rdy) begin
                m_word = w;
                m_perr = p;
            end else if (done) begin
                m_ovf = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end else if (done) begin
            m_valid = 1'b1;
            m_word  = w;
            m_perr  = p;
        end
    endtask

    task automatic check_model();
        logic [2:0] exp_sel;
        exp_sel = 3'(bits_q.size() % 8);
        check("dout_lsb", dout_l, m_word);
        check("dout_msb", dout_m, rev8(m_word));
        check("valid_lsb", valid_l, m_valid);
        check("valid_msb", valid_m, m_valid);
        check("state_dbg", st_l, m_valid);
        check("sel_lsb", sel_l, exp_sel);
        check("sel_msb", sel_m, exp_sel);
        check("overflow_lsb", ovf_l, m_ovf);
        check("overflow_msb", ovf_m, m_ovf);
        check("parity_err", perr_l, m_perr);
        check("parity_err_msb", perr_m, m_perr);
    endtask

    // driver: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge
    task automatic step(input logic d, input logic dv, input logic rdy, input logic clr);
        @(negedge clk);
        din = d; din_valid = dv; dout_ready = rdy; sync_clr = clr;
        @(posedge clk);
        model_edge(d, dv, rdy, clr);
        #1;
        check_model();
    endtask

    task automatic send_word(input logic [7:0] b, input logic pbit, input logic rdy,
                             input logic rdy_last, input logic gaps);
        for (int k = 0; k < FRAME; k++) begin
            logic bit_v;
            bit_v = (k < 8) ? b[k] : pbit;
            if (gaps) step(1'b0, 1'b0, rdy, 1'b0);
            step(bit_v, 1'b1, (k == FRAME - 1) ? rdy_last : rdy, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; sync_clr = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", dout_l, 8'h00);
        check("reset_valid", valid_l, 1'b0);
        check("reset_sel", sel_l, 3'd0);
        check("reset_ovf", ovf_l, 1'b0);
        check("reset_perr", perr_l, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven bytes, consumer always ready
        vecs[0] = '{8'hAA, 8'hAA, 8'h55};
        vecs[1] = '{8'hCC, 8'hCC, 8'h33};
        vecs[2] = '{8'h0F, 8'h0F, 8'hF0};
        vecs[3] = '{8'h5A, 8'h5A, 8'h5A};
        vecs[4] = '{8'h01, 8'h01, 8'h80};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].byte_in, ^vecs[i].byte_in, 1'b1, 1'b1, 1'b0);
            check("vec_dout_lsb", dout_l, vecs[i].exp_lsb);
            check("vec_dout_msb", dout_m, vecs[i].exp_msb);
            check("vec_valid", valid_l, 1'b1);
            check("vec_sel_wrap", sel_l, 3'd0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("vec_valid_one_cycle", valid_l, 1'b0);
        end

        // gaps between bits must not shift slots
        send_word(8'hCC, ^8'hCC, 1'b1, 1'b1, 1'b1);
        check("gap_dout_msb", dout_m, 8'h33);
        check("gap_dout_lsb", dout_l, 8'hCC);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // backpressure: second word dropped, overflow sticky until sync_clr
        send_word(8'h0F, ^8'h0F, 1'b0, 1'b0, 1'b0);
        send_word(8'hF0, ^8'hF0, 1'b0, 1'b0, 1'b0);
        check("bp_dout", dout_l, 8'h0F);
        check("bp_ovf", ovf_l, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_ovf_sticky", ovf_l, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("bp_clr_ovf", ovf_l, 1'b0);
        check("bp_clr_dout", dout_l, 8'h0F);
        check("bp_clr_valid", valid_l, 1'b1);
        check("bp_clr_sel", sel_l, 3'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // handoff and completion on the same edge: no bubble
        send_word(8'h3C, ^8'h3C, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, ^8'hC3, 1'b0, 1'b1, 1'b0);
        check("b2b_dout", dout_l, 8'hC3);
        check("b2b_valid", valid_l, 1'b1);
        check("b2b_ovf", ovf_l, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // abort a partial word
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(8'h5A, ^8'h5A, 1'b1, 1'b1, 1'b0);
        check("abort_dout", dout_l, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-word, with a word pending
        send_word(8'h96, ^8'h96, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dout", dout_l, 8'h00);
        check("async_rst_valid", valid_l, 1'b0);
        check("async_rst_sel", sel_l, 3'd0);
        check("async_rst_perr", perr_l, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hA5, ^8'hA5, 1'b1, 1'b1, 1'b0);
        check("post_rst_dout", dout_l, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DEMUX_PARITY_EN
        send_word(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
        check("parity_ok", perr_l, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'hAB, 1'b0, 1'b1, 1'b1, 1'b0);
        check("parity_bad", perr_l, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // randomized traffic against the model; record delivered words in order
        for (int n = 0; n < 2000; n++) begin
            logic d, dv, rdy, clr;
            d   = 1'($urandom_range(0, 1));
            dv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 39) == 0);
            if (m_valid && rdy) exp_q.push_back(m_word);
            step(d, dv, rdy, clr);
        end
        check("random_traffic_words", (exp_q.size() > 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
